// File: rtl/tj_trigger_seq.sv
// Trigger stage: fires Tj_Trig after the ordered plaintexts P0,P1,P2,P3 are accepted within TIMEOUT_CYC cycles.
// Optional macro TJ_TRIG_STICKY_EN: the trigger latches high until rst instead of pulsing.
module tj_trigger_seq #(
  parameter logic [127:0] P0             = 128'h00112233_44556677_8899aabb_ccddeeff,
  parameter logic [127:0] P1             = 128'h11111111_11111111_11111111_11111111,
  parameter logic [127:0] P2             = 128'h22222222_22222222_22222222_22222222,
  parameter logic [127:0] P3             = 128'h33333333_33333333_33333333_33333333,
  parameter int unsigned  TIMEOUT_CYC    = 1000,
  parameter int unsigned  TRIG_PULSE_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state_in,
  input  logic         state_vld,
  output logic         Tj_Trig,
  output logic [2:0]   seq_stage,
  output logic [7:0]   fire_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    FIRE = 3'd4
  } state_t;

  localparam int unsigned     TO_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tj_trig_q, tj_trig_d;
  logic [7:0]      fire_cnt_q, fire_cnt_d;

  logic            is_p0, is_p1, is_p2, is_p3;
  logic            to_hit;
  logic            seq_hit;
  state_t          seq_next;

  assign is_p0  = state_vld && (state_in == P0);
  assign is_p1  = state_vld && (state_in == P1);
  assign is_p2  = state_vld && (state_in == P2);
  assign is_p3  = state_vld && (state_in == P3);
  // The gap between consecutive matches may be at most TIMEOUT_CYC edges.
  assign to_hit = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST);

`ifndef TJ_TRIG_STICKY_EN
  localparam logic [7:0] PULSE_LAST = 8'(TRIG_PULSE_LEN - 1);

  logic [7:0] pulse_q, pulse_d;

  always_comb begin
    pulse_d = '0;
    if (state_q == FIRE && state_d == FIRE) pulse_d = pulse_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) pulse_q <= '0;
    else     pulse_q <= pulse_d;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      tj_trig_q  <= 1'b0;
      fire_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      tj_trig_q  <= tj_trig_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    to_cnt_d = '0;
    seq_hit  = 1'b0;
    seq_next = IDLE;

    unique case (state_q)
      M0:      begin seq_hit = is_p1; seq_next = M1;   end
      M1:      begin seq_hit = is_p2; seq_next = M2;   end
      M2:      begin seq_hit = is_p3; seq_next = FIRE; end
      default: ;
    endcase

    unique case (state_q)
      IDLE: if (is_p0) state_d = M0;
      M0, M1, M2: begin
        if (state_vld) begin
          if (seq_hit)    state_d = seq_next;
          else if (is_p0) state_d = M0;
          else            state_d = IDLE;
        end else if (to_hit) begin
          state_d = IDLE;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      FIRE: begin
`ifdef TJ_TRIG_STICKY_EN
        state_d = FIRE;
`else
        if (pulse_q == PULSE_LAST) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered copies of the next state's view.
  always_comb begin
    tj_trig_d  = (state_d == FIRE);
    fire_cnt_d = fire_cnt_q;
    if (state_d == FIRE && state_q != FIRE && fire_cnt_q != 8'hff)
      fire_cnt_d = fire_cnt_q + 8'd1;
  end

  assign Tj_Trig   = tj_trig_q;
  assign seq_stage = state_q;
  assign fire_cnt  = fire_cnt_q;

endmodule

// File: tb/tb_tj_trigger_seq.sv
// Directed bench for tj_trigger_seq: pulse timing, restart, timeout boundary, reset in FIRE, saturation.
// Build with TJ_TRIG_STICKY_EN to exercise the sticky variant instead of the pulsed tests.
module tb_tj_trigger_seq;

  localparam logic [127:0] P0   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] P1   = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] P2   = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] P3   = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] DEAD = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state_in;
  logic         state_vld;
  logic         tj_trig;
  logic [2:0]   seq_stage;
  logic [7:0]   fire_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  tj_trigger_seq dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .state_vld (state_vld),
    .Tj_Trig   (tj_trig),
    .seq_stage (seq_stage),
    .fire_cnt  (fire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present inputs, take the edge, then settle 1 time unit past it.
  task automatic cyc(input logic v, input logic [127:0] d);
    state_vld = v;
    state_in  = d;
    @(posedge clk);
    #1;
    state_vld = 1'b0;
    state_in  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0);
  endtask

  task automatic fire_seq();
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
  endtask

  initial begin
    int hi_cnt;
    int lo_cnt;

    rst       = 1'b1;
    state_vld = 1'b0;
    state_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig",  32'(tj_trig),   32'd0);
    check("rst_stage", 32'(seq_stage), 32'd0);
    check("rst_fcnt",  32'(fire_cnt),  32'd0);
    rst = 1'b0;

`ifdef TJ_TRIG_STICKY_EN
    fire_seq();
    check("sticky_rise", 32'(tj_trig), 32'd1);
    lo_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      case (i % 4)
        0: cyc(1'($urandom_range(0, 1)), P0);
        1: cyc(1'($urandom_range(0, 1)), P1);
        2: cyc(1'($urandom_range(0, 1)), P2);
        default: cyc(1'($urandom_range(0, 1)), P3);
      endcase
      if (tj_trig !== 1'b1) lo_cnt++;
    end
    check("sticky_low_cycles", 32'(lo_cnt),    32'd0);
    check("sticky_stage",      32'(seq_stage), 32'd4);
    check("sticky_fcnt",       32'(fire_cnt),  32'd1);
    rst = 1'b1;
    cyc(1'b0, '0);
    rst = 1'b0;
    check("sticky_rst_trig", 32'(tj_trig),  32'd0);
    check("sticky_rst_fcnt", 32'(fire_cnt), 32'd0);
`else
    // Pulse timing; P0 offered during FIRE must be ignored.
    cyc(1'b1, P0);
    check("t1_stage_m0", 32'(seq_stage), 32'd1);
    cyc(1'b1, P1);
    check("t1_stage_m1", 32'(seq_stage), 32'd2);
    cyc(1'b1, P2);
    check("t1_stage_m2", 32'(seq_stage), 32'd3);
    check("t1_no_early_trig", 32'(tj_trig), 32'd0);
    cyc(1'b1, P3);
    check("t1_trig_rise", 32'(tj_trig),   32'd1);
    check("t1_stage_fire", 32'(seq_stage), 32'd4);
    check("t1_fcnt",      32'(fire_cnt),  32'd1);
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (tj_trig === 1'b1) hi_cnt++;
      cyc(1'b1, P0);
    end
    check("t1_pulse_len",   32'(hi_cnt),    32'd4);
    check("t1_trig_fall",   32'(tj_trig),   32'd0);
    check("t1_stage_after", 32'(seq_stage), 32'd0);

    // Broken sequence must not fire.
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, DEAD);
    check("t2_dead_idle", 32'(seq_stage), 32'd0);
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
    check("t2_no_trig",  32'(tj_trig),   32'd0);
    check("t2_stage",    32'(seq_stage), 32'd0);
    // P0 in M1 restarts the sequence.
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, P0);
    check("t2_restart_m0", 32'(seq_stage), 32'd1);
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
    check("t2_restart_trig", 32'(tj_trig),  32'd1);
    check("t2_restart_fcnt", 32'(fire_cnt), 32'd2);
    idle(4);
    // P0 repeated in M0 stays in M0.
    cyc(1'b1, P0);
    cyc(1'b1, P0);
    check("t2_m0_hold", 32'(seq_stage), 32'd1);
    cyc(1'b1, P1);
    check("t2_m0_hold_adv", 32'(seq_stage), 32'd2);
    cyc(1'b1, DEAD);

    // 1000-cycle gap after P1 times out on the 1000th idle edge.
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    idle(999);
    check("t3_before_timeout", 32'(seq_stage), 32'd2);
    idle(1);
    check("t3_timeout_idle", 32'(seq_stage), 32'd0);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
    check("t3_timeout_no_trig", 32'(tj_trig), 32'd0);
    // 999-cycle gap: P2 lands on the timeout edge and the match wins.
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    idle(999);
    cyc(1'b1, P2);
    check("t3_collision_m2", 32'(seq_stage), 32'd3);
    cyc(1'b1, P3);
    check("t3_gap999_trig", 32'(tj_trig),  32'd1);
    check("t3_gap999_fcnt", 32'(fire_cnt), 32'd3);
    idle(4);

    // Reset on the second FIRE cycle.
    fire_seq();
    check("t4_fcnt", 32'(fire_cnt), 32'd4);
    idle(1);
    check("t4_fire_2nd", 32'(tj_trig), 32'd1);
    rst = 1'b1;
    cyc(1'b0, '0);
    rst = 1'b0;
    check("t4_rst_trig",  32'(tj_trig),   32'd0);
    check("t4_rst_stage", 32'(seq_stage), 32'd0);
    check("t4_rst_fcnt",  32'(fire_cnt),  32'd0);

    // fire_cnt saturation.
    for (int i = 1; i <= 300; i++) begin
      fire_seq();
      idle(4);
      if (i == 254) check("t5_fcnt_254", 32'(fire_cnt), 32'd254);
    end
    check("t5_fcnt_sat", 32'(fire_cnt), 32'd255);
    check("t5_stage",    32'(seq_stage), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
